// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: clocked front end for the asynchronous memory. Turns a
// one-cycle request into the memory's EN/MFC edge handshake, synchronizes
// MFC, bounds each handshake edge with a timeout, and reports completion
// with a one-cycle done pulse (err qualifies done).
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] MAR_to_MEM,
    output logic [15:0] MDR_to_MEM,
    output logic        RW,
    output logic        EN,
    input  logic        MFC,
    input  logic [15:0] MEM_to_MDR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_flag_q, err_flag_d;
    logic [15:0]            mar_q, mar_d;
    logic [15:0]            mdr_q, mdr_d;
    logic                   rw_q, rw_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            rdata_q, rdata_d;

    logic mfc_s;
    logic cnt_max;

    // MFC is asynchronous to clk; only the last synchronizer stage is used.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], MFC};
    assign mfc_s   = sync_q[SYNC_STAGES-1];
    assign cnt_max = (cnt_q == CNT_MAX);

    // State register plus every registered output and datapath flop.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same edge, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            mar_q      <= '0;
            mdr_q      <= '0;
            rw_q       <= 1'b1;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            rw_q       <= rw_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic: each handshake edge ends on MFC or on timeout.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (req)                state_d = S_SETUP;
            S_SETUP:   if (!mfc_s)             state_d = S_STROBE;
            S_STROBE:  if (mfc_s || cnt_max)   state_d = S_RELEASE;
            S_RELEASE: if (!mfc_s || cnt_max)  state_d = S_DONE;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: bus latching, timeout counter, read capture.
    always_comb begin
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    mar_d      = req_addr;
                    mdr_d      = req_wdata;
                    rw_d       = req_rw;
                    err_flag_d = 1'b0;
                end
            end
            S_SETUP: cnt_d = '0;
            S_STROBE: begin
                if (mfc_s) begin
                    if (rw_q) rdata_d = MEM_to_MDR;
                    cnt_d = '0;
                end else if (cnt_max) begin
                    err_flag_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (mfc_s) begin
                    if (cnt_max) err_flag_d = 1'b1;
                    else         cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // EN is high only for cycles spent in STROBE after the first one,
        // and drops on the same edge that leaves STROBE.
        en_d   = (state_q == S_STROBE) && (state_d == S_STROBE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = done_d && err_flag_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign MAR_to_MEM = mar_q;
    assign MDR_to_MEM = mdr_q;
    assign RW         = rw_q;
    assign EN         = en_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: behavioural asynchronous memory, scoreboard
// of expected completions from a reference model, decoupled monitors.
module tb_mem_bus_ctrl;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        busy, done, err, RW, EN;
    logic [15:0] rdata, MAR_to_MEM, MDR_to_MEM;
    logic        MFC = 1'b0;
    logic [15:0] MEM_to_MDR = '0;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .MAR_to_MEM(MAR_to_MEM),
        .MDR_to_MEM(MDR_to_MEM), .RW(RW), .EN(EN), .MFC(MFC),
        .MEM_to_MDR(MEM_to_MDR)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: acts 5 ns after EN rises, drops MFC 5 ns after EN falls.
    logic [15:0] mem [64];
    logic        mfc_stuck = 1'b0;

    always @(posedge EN) begin
        if (!mfc_stuck) begin
            #5;
            if (EN) begin
                if (RW) MEM_to_MDR = mem[MAR_to_MEM[5:0]];
                else    mem[MAR_to_MEM[5:0]] = MDR_to_MEM;
                MFC = 1'b1;
            end
        end
    end

    always @(negedge EN) begin
        #5;
        MFC = 1'b0;
    end

    // Reference model and scoreboard.
    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic        rw;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          en_exp[$];
    logic [15:0] ref_mem [64];
    logic [15:0] model_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic rw, input logic [15:0] addr,
                                   input logic [15:0] wd, input logic stuck);
        exp_t e;
        e.addr = addr;
        e.rw   = rw;
        e.acc  = 0;
        if (stuck) begin
            e.err = 1'b1;
            e.lat = T + 3;
        end else begin
            e.err = 1'b0;
            e.lat = 8;
            if (rw) model_rdata = ref_mem[addr[5:0]];
            else    ref_mem[addr[5:0]] = wd;
        end
        e.rdata = model_rdata;
        return e;
    endfunction

    // Completion monitor: every done pulse must match the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err",     32'(err),        32'(mon_e.err));
                    check("rdata",   32'(rdata),      32'(mon_e.rdata));
                    check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    check("mar",     32'(MAR_to_MEM), 32'(mon_e.addr));
                    check("rw",      32'(RW),         32'(mon_e.rw));
                end
            end else if (err) begin
                check("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    // EN pulse-width monitor.
    int en_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            en_cnt = 0;
        end else if (EN) begin
            en_cnt++;
        end else if (en_cnt != 0) begin
            if (en_exp.size() == 0) check("spurious_en", 32'(en_cnt), 32'd0);
            else                    check("en_len", 32'(en_cnt), 32'(en_exp.pop_front()));
            en_cnt = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic rw, input logic [15:0] addr,
                         input logic [15:0] wd, input logic stuck);
        exp_t e;
        wait_idle();
        mfc_stuck = stuck;
        req = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; req_rw = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
        e = model(rw, addr, wd, stuck);
        e.acc = cyc;
        sb.push_back(e);
        en_exp.push_back(stuck ? T : 3);
    endtask

    // Hold req high through a read, scramble inputs while busy, then chain
    // a second read on the first idle edge.
    task automatic back_to_back();
        exp_t e;
        int n;
        wait_idle();
        req = 1'b1; req_rw = 1'b1; req_addr = 16'h0002;
        @(posedge clk);
        #1;
        e = model(1'b1, 16'h0002, 16'h0000, 1'b0);
        e.acc = cyc;
        sb.push_back(e);
        en_exp.push_back(3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) begin
                req = 1'($urandom); req_rw = 1'($urandom);
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end
        end while (busy && n < 50);
        req = 1'b1; req_rw = 1'b1; req_addr = 16'h0003;
        @(posedge clk);
        #1;
        e = model(1'b1, 16'h0003, 16'h0000, 1'b0);
        e.acc = cyc;
        sb.push_back(e);
        en_exp.push_back(3);
        repeat (5) begin
            @(negedge clk);
            req = 1'($urandom); req_rw = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
        end
        req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'($urandom);
        end
        mem[1] = 16'hF0AF;
        mem[2] = 16'h0042;
        mem[3] = 16'h7101;
        mem[4] = 16'h5081;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

        // Asynchronous reset with the clock stopped.
        #3 reset = 1'b1;
        #1;
        check("rst_en",    32'(EN),         32'd0);
        check("rst_rw",    32'(RW),         32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_rdata", 32'(rdata),      32'd0);
        check("rst_mar",   32'(MAR_to_MEM), 32'd0);
        check("rst_mdr",   32'(MDR_to_MEM), 32'd0);
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(1'b1, 16'h0001, 16'h0000, 1'b0);
        issue(1'b0, 16'h0020, 16'h1234, 1'b0);
        issue(1'b1, 16'h0020, 16'h0000, 1'b0);
        back_to_back();
        issue(1'b1, 16'h0005, 16'h0000, 1'b1);

        // Reset in the middle of STROBE abandons the access.
        wait_idle();
        mfc_stuck = 1'b0;
        req = 1'b1; req_rw = 1'b1; req_addr = 16'h0004;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("en_before_rst", 32'(EN), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_strobe_en",    32'(EN),    32'd0);
        check("rst_strobe_busy",  32'(busy),  32'd0);
        check("rst_strobe_rdata", 32'(rdata), 32'd0);
        model_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 16'h0004, 16'h0000, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()),     32'd0);
        check("en_empty", 32'(en_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Clocked bus controller sitting directly upstream of the asynchronous memory. It accepts single-word read/write requests from the CPU control unit and drives the memory's MAR/MDR/RW/EN pins. It waits for the memory's MFC completion strobe, returns read data and signals completion. It converts the memory's edge-triggered EN/MFC handshake into a one-clock request/done protocol, with a synchronizer and a timeout.

## Interface
- TIMEOUT_CYCLES, 64, maximum cycles to wait for each MFC edge before aborting; must be ≥ 2.
- SYNC_STAGES, 2, flip-flop stages on the MFC synchronizer; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe from control unit; sampled only in IDLE.
- req_rw  in  1  1 = read, 0 = write (same encoding as memory RW).
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag; valid only while done = 1.
- rdata  out  16  last successfully read word; held until next successful read.
- MAR_to_MEM  out  16  address to memory.
- MDR_to_MEM  out  16  write data to memory.
- RW  out  1  read/write select to memory.
- EN  out  1  memory enable; the memory acts on its rising edge.
- MFC  in  1  memory-function-complete; asynchronous to clk; rises after EN rises, falls when EN falls.
- MEM_to_MDR  in  16  read data from memory; valid while MFC = 1.

## Operation
- MFC passes through a SYNC_STAGES synchronizer; mfc_s is the synchronized output. The FSM uses only mfc_s.
- All outputs are registered.

States and transitions:
- IDLE: if req = 1, latch req_addr into MAR_to_MEM, req_wdata into MDR_to_MEM, and req_rw into RW, clear the error flag, then go to SETUP. req is ignored in every other state.
- SETUP: EN = 0 for one settle cycle. Advance to STROBE only when mfc_s = 0; otherwise stay. Clear the counter.
- STROBE: EN = 1 and the counter increments.
  - If mfc_s = 1: on a read, register MEM_to_MDR into rdata; go to RELEASE.
  - Else if the counter reaches TIMEOUT_CYCLES: set the error flag and go to RELEASE. rdata is unchanged.
- RELEASE: EN = 0 and the counter restarts from 0.
  - If mfc_s = 0, go to DONE.
  - Else if the counter reaches TIMEOUT_CYCLES, set the error flag and go to DONE.
- DONE: done = 1 and err = error flag for exactly one cycle, then IDLE.

Data and bus rules:
- MAR_to_MEM, MDR_to_MEM and RW are stable from SETUP through DONE, so the memory samples stable values on the EN rising edge.
- Writes never modify rdata.
- Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.

Reset (asynchronous, any state):
- State goes to IDLE; EN=0, RW=1, MAR_to_MEM=0, MDR_to_MEM=0, rdata=0, done=0, err=0, busy=0.
- Synchronizer flops and counter go to 0.
- An in-flight access is abandoned with no done pulse. EN falling causes the memory to drop MFC.

## Timing
- Request accepted on edge A (req = 1 in IDLE); busy rises after edge A.
- EN rises after edge A+2.
- With MFC rising within the first clk period of EN (10 ns clk, 5 ns memory delay), SYNC_STAGES = 2:
  - mfc_s = 1 after A+4.
  - rdata is valid and EN falls after A+5.
  - mfc_s = 0 after A+7.
  - done = 1 during the cycle after A+8; busy = 0 after A+9.
  - Nominal access is 9 cycles accept-to-idle.
- Each added synchronizer stage adds 2 cycles, one per MFC edge.
- Earliest next acceptance is edge A+10 if req is held high.
- Timeout case: EN is high for exactly TIMEOUT_CYCLES cycles, then the FSM goes to RELEASE.
- done and err are never asserted outside the DONE state.

## Test plan
- Reset: assert reset mid-cycle with no clock → all outputs at reset values immediately; EN=0, RW=1, busy=0.
- Read address 0x0001 against the behavioral memory (10 ns clk) → EN high for cycles A+3..A+5; done pulse in cycle A+9; rdata=0xF0AF; err=0.
- Write 0x1234 to 0x0020, then read 0x0020 → rdata=0x1234; err=0 on both; rdata unchanged after the write's done.
- Back-to-back reads of 0x0002 and 0x0003 with req held high; toggle req during busy → exactly two done pulses; rdata=0x0042 then 0x7101; requests during busy ignored.
- MFC tied low, TIMEOUT_CYCLES=64 → EN high exactly 64 cycles; done=1 and err=1 in the same cycle; rdata retains its prior value.
- Reset asserted while in STROBE → EN drops asynchronously; no done pulse; a subsequent read of 0x0004 returns 0x5081 with err=0.
